// File: rtl/proj_fm_sweep_ctrl.sv
// proj_fm_sweep_ctrl: round-robin arbitrated index sweeps over FM buffers with back-pressure and abort
module proj_fm_sweep_ctrl #(
    parameter int NUM_BUFS = 4,
    parameter int FM_BUFFER_SIZE = 8,
    localparam int SEL_W = NUM_BUFS > 1 ? $clog2(NUM_BUFS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_BUFS-1:0]       req,
    input  logic                      abort,
    input  logic                      sweep_ready,
    output logic                      rd_valid,
    output logic [SEL_W-1:0]          rd_buf_sel,
    output logic [FM_BUFFER_SIZE-1:0] rd_index,
    output logic                      rd_last,
    output logic [NUM_BUFS-1:0]       ack,
    output logic                      busy
);
    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
    localparam logic [FM_BUFFER_SIZE-1:0] last_idx = FM_BUFFER_SIZE'(FM_BUFFER_SIZE - 1);
    state_t state;
    logic [SEL_W-1:0] ptr, gnt, nxt_ptr;
    always_comb begin
        gnt = '0;
        for (int i = NUM_BUFS - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % NUM_BUFS]) gnt = SEL_W'((int'(ptr) + i) % NUM_BUFS);
    end
    assign nxt_ptr = SEL_W'((int'(rd_buf_sel) + 1) % NUM_BUFS);
    assign rd_valid = state == SWEEP;
    assign busy = state != IDLE;
    assign rd_last = rd_valid && rd_index == last_idx;
    assign ack = state == DONE ? NUM_BUFS'(1) << rd_buf_sel : '0;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            rd_buf_sel <= '0;
            rd_index <= '0;
            ptr <= '0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    state <= SWEEP;
                    rd_buf_sel <= gnt;
                    rd_index <= '0;
                end
                SWEEP: if (abort) begin
                    state <= IDLE;
                    rd_index <= '0;
                    ptr <= nxt_ptr;
                end else if (sweep_ready) begin
                    state <= rd_index == last_idx ? DONE : SWEEP;
                    rd_index <= rd_index == last_idx ? '0 : rd_index + 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    ptr <= nxt_ptr;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
